// File: rtl/fcc_uf_pkg.sv
// fcc_uf_pkg: shared types and default sizes for the FCC union-find label resolver.
package fcc_uf_pkg;
  localparam int LABEL_W_DEF  = 16;
  localparam int N_LABELS_DEF = 4096;
  localparam int IDX_W_DEF    = $clog2(N_LABELS_DEF);

  typedef logic [LABEL_W_DEF-1:0] label_t;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    QFIND,
    FIND_A,
    FIND_B,
    LINK,
    COMPRESS
  } state_e;
endpackage

// File: rtl/fcc_union_find_if.sv
// fcc_union_find_if: merge request, root query and query result handshakes of the resolver.
interface fcc_union_find_if
  import fcc_uf_pkg::*;
#(
  parameter int LABEL_W = LABEL_W_DEF
) ();
  logic               merge_valid;
  logic [LABEL_W-1:0] merge_a;
  logic [LABEL_W-1:0] merge_b;
  logic               merge_ready;
  logic               q_valid;
  logic [LABEL_W-1:0] q_label;
  logic               q_ready;
  logic               q_out_valid;
  logic [LABEL_W-1:0] q_root;

  modport master (
    output merge_valid, merge_a, merge_b, q_valid, q_label,
    input  merge_ready, q_ready, q_out_valid, q_root
  );

  modport slave (
    input  merge_valid, merge_a, merge_b, q_valid, q_label,
    output merge_ready, q_ready, q_out_valid, q_root
  );
endinterface

// File: rtl/fcc_uf_parent_ram.sv
// fcc_uf_parent_ram: 1R1W parent-pointer RAM with registered read; a read of the
// address being written in the same cycle returns the new data.
module fcc_uf_parent_ram
  import fcc_uf_pkg::*;
#(
  parameter int DEPTH = N_LABELS_DEF,
  parameter int AW    = IDX_W_DEF,
  parameter int DW    = IDX_W_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/fcc_union_find.sv
// fcc_union_find: union-find root resolver; links the larger root under the smaller one.
// Define FCC_UF_PATH_COMPRESS_EN to add a parent[start]=root write after multi-hop finds.
module fcc_union_find
  import fcc_uf_pkg::*;
#(
  parameter int LABEL_W  = LABEL_W_DEF,
  parameter int N_LABELS = N_LABELS_DEF,
  parameter int IDX_W    = IDX_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  fcc_union_find_if.slave uf_if,
  output logic            init_done,
  output logic            lbl_overflow
);
  typedef logic [LABEL_W-1:0] lbl_t;
  typedef logic [IDX_W-1:0]   idx_t;

  state_e state_q, state_d;
  idx_t   init_cnt_q, init_cnt_d;
  idx_t   cur_q, cur_d;
  idx_t   ra_q, ra_d;
  idx_t   waddr_q, waddr_d;
  idx_t   wdata_q, wdata_d;
  logic   rd_vld_q, rd_vld_d;
  logic   we_q, we_d;
  logic   init_done_q, init_done_d;
  logic   ovf_q, ovf_d;
  logic   m_pend_q, m_pend_d;
  logic   q_pend_q, q_pend_d;
  logic   q_first_q, q_first_d;
  logic   q_out_valid_q, q_out_valid_d;
  lbl_t   m_a_q, m_a_d;
  lbl_t   m_b_q, m_b_d;
  lbl_t   q_lbl_q, q_lbl_d;
  lbl_t   q_root_q, q_root_d;
`ifdef FCC_UF_PATH_COMPRESS_EN
  idx_t   start_q, start_d;
  logic   hop_q, hop_d;
  state_e ret_q, ret_d;
`endif

  logic merge_ready_w, q_ready_w, m_acc, q_acc, m_oor, q_oor, found, q_go;
  logic ram_we;
  idx_t ram_waddr, ram_wdata, ram_raddr, ram_rdata;

  function automatic logic is_oor(input lbl_t l);
    return {1'b0, l} >= (LABEL_W+1)'(N_LABELS);
  endfunction

  assign merge_ready_w = init_done_q & ~m_pend_q;
  assign q_ready_w     = init_done_q & ~q_pend_q;
  assign m_acc         = uf_if.merge_valid & merge_ready_w;
  assign q_acc         = uf_if.q_valid & q_ready_w;
  assign m_oor         = is_oor(m_a_q) | is_oor(m_b_q);
  assign q_oor         = is_oor(q_lbl_q);
  assign found         = rd_vld_q & (ram_rdata == cur_q);
  assign q_go          = q_pend_q & (~m_pend_q | q_first_q);

  // Once a read is in flight the next address is the pointer just read, so a hop costs one cycle.
  assign ram_raddr = rd_vld_q ? ram_rdata : cur_q;
  assign ram_we    = (state_q == INIT) | we_q;
  assign ram_waddr = (state_q == INIT) ? init_cnt_q : waddr_q;
  assign ram_wdata = (state_q == INIT) ? init_cnt_q : wdata_q;

  fcc_uf_parent_ram #(
    .DEPTH (N_LABELS),
    .AW    (IDX_W),
    .DW    (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    cur_d         = cur_q;
    ra_d          = ra_q;
    waddr_d       = waddr_q;
    wdata_d       = wdata_q;
    rd_vld_d      = rd_vld_q;
    we_d          = 1'b0;
    init_done_d   = init_done_q;
    ovf_d         = ovf_q;
    m_pend_d      = m_pend_q;
    q_pend_d      = q_pend_q;
    q_first_d     = q_first_q;
    q_out_valid_d = 1'b0;
    m_a_d         = m_a_q;
    m_b_d         = m_b_q;
    q_lbl_d       = q_lbl_q;
    q_root_d      = q_root_q;
`ifdef FCC_UF_PATH_COMPRESS_EN
    start_d       = start_q;
    hop_d         = hop_q;
    ret_d         = ret_q;
`endif

    if (m_acc) begin
      m_pend_d = 1'b1;
      m_a_d    = uf_if.merge_a;
      m_b_d    = uf_if.merge_b;
    end
    if (q_acc) begin
      q_pend_d = 1'b1;
      q_lbl_d  = uf_if.q_label;
    end
    // q_first_d marks the query as the older of the two pending entries.
    if (m_acc && q_acc) begin
      q_first_d = 1'b0;
    end else if (q_acc) begin
      q_first_d = ~m_pend_q;
    end else if (m_acc) begin
      q_first_d = q_pend_q;
    end
    if ((m_acc && (is_oor(uf_if.merge_a) || is_oor(uf_if.merge_b))) ||
        (q_acc && is_oor(uf_if.q_label))) begin
      ovf_d = 1'b1;
    end

    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == IDX_W'(N_LABELS - 1)) begin
          init_done_d = 1'b1;
          init_cnt_d  = '0;
          state_d     = IDLE;
        end
      end
      IDLE: begin
        if (q_go) begin
          state_d  = QFIND;
          cur_d    = q_lbl_q[IDX_W-1:0];
          rd_vld_d = 1'b0;
`ifdef FCC_UF_PATH_COMPRESS_EN
          start_d  = q_lbl_q[IDX_W-1:0];
          hop_d    = 1'b0;
`endif
        end else if (m_pend_q) begin
          if (m_oor) begin
            m_pend_d = 1'b0;
          end else begin
            state_d  = FIND_A;
            cur_d    = m_a_q[IDX_W-1:0];
            rd_vld_d = 1'b0;
`ifdef FCC_UF_PATH_COMPRESS_EN
            start_d  = m_a_q[IDX_W-1:0];
            hop_d    = 1'b0;
`endif
          end
        end
      end
      QFIND: begin
        if (!rd_vld_q) begin
          rd_vld_d = 1'b1;
        end else if (q_oor || found) begin
          q_out_valid_d = 1'b1;
          q_root_d      = q_oor ? q_lbl_q : lbl_t'(cur_q);
          q_pend_d      = 1'b0;
          state_d       = IDLE;
`ifdef FCC_UF_PATH_COMPRESS_EN
          if (hop_q) begin
            state_d = COMPRESS;
            ret_d   = IDLE;
            we_d    = 1'b1;
            waddr_d = start_q;
            wdata_d = cur_q;
          end
`endif
        end else begin
          cur_d = ram_rdata;
`ifdef FCC_UF_PATH_COMPRESS_EN
          hop_d = 1'b1;
`endif
        end
      end
      FIND_A: begin
        if (!rd_vld_q) begin
          rd_vld_d = 1'b1;
        end else if (found) begin
          ra_d     = cur_q;
          cur_d    = m_b_q[IDX_W-1:0];
          rd_vld_d = 1'b0;
          state_d  = FIND_B;
`ifdef FCC_UF_PATH_COMPRESS_EN
          start_d  = m_b_q[IDX_W-1:0];
          hop_d    = 1'b0;
          if (hop_q) begin
            state_d = COMPRESS;
            ret_d   = FIND_B;
            we_d    = 1'b1;
            waddr_d = start_q;
            wdata_d = cur_q;
          end
`endif
        end else begin
          cur_d = ram_rdata;
`ifdef FCC_UF_PATH_COMPRESS_EN
          hop_d = 1'b1;
`endif
        end
      end
      FIND_B: begin
        if (!rd_vld_q) begin
          rd_vld_d = 1'b1;
        end else if (found) begin
          state_d = LINK;
`ifdef FCC_UF_PATH_COMPRESS_EN
          if (hop_q) begin
            state_d = COMPRESS;
            ret_d   = LINK;
            we_d    = 1'b1;
            waddr_d = start_q;
            wdata_d = cur_q;
          end
`endif
        end else begin
          cur_d = ram_rdata;
`ifdef FCC_UF_PATH_COMPRESS_EN
          hop_d = 1'b1;
`endif
        end
      end
      LINK: begin
        // cur_q holds rb here; the smaller root always becomes the parent.
        if (ra_q != cur_q) begin
          we_d    = 1'b1;
          waddr_d = (ra_q > cur_q) ? ra_q : cur_q;
          wdata_d = (ra_q > cur_q) ? cur_q : ra_q;
        end
        m_pend_d = 1'b0;
        state_d  = IDLE;
      end
      COMPRESS: begin
`ifdef FCC_UF_PATH_COMPRESS_EN
        state_d = ret_q;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = INIT;
    endcase

    if (clear) begin
      state_d       = INIT;
      init_cnt_d    = '0;
      init_done_d   = 1'b0;
      m_pend_d      = 1'b0;
      q_pend_d      = 1'b0;
      ovf_d         = 1'b0;
      we_d          = 1'b0;
      q_out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= INIT;
      init_cnt_q    <= '0;
      cur_q         <= '0;
      ra_q          <= '0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      rd_vld_q      <= 1'b0;
      we_q          <= 1'b0;
      init_done_q   <= 1'b0;
      ovf_q         <= 1'b0;
      m_pend_q      <= 1'b0;
      q_pend_q      <= 1'b0;
      q_first_q     <= 1'b0;
      q_out_valid_q <= 1'b0;
      m_a_q         <= '0;
      m_b_q         <= '0;
      q_lbl_q       <= '0;
      q_root_q      <= '0;
`ifdef FCC_UF_PATH_COMPRESS_EN
      start_q       <= '0;
      hop_q         <= 1'b0;
      ret_q         <= IDLE;
`endif
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      cur_q         <= cur_d;
      ra_q          <= ra_d;
      waddr_q       <= waddr_d;
      wdata_q       <= wdata_d;
      rd_vld_q      <= rd_vld_d;
      we_q          <= we_d;
      init_done_q   <= init_done_d;
      ovf_q         <= ovf_d;
      m_pend_q      <= m_pend_d;
      q_pend_q      <= q_pend_d;
      q_first_q     <= q_first_d;
      q_out_valid_q <= q_out_valid_d;
      m_a_q         <= m_a_d;
      m_b_q         <= m_b_d;
      q_lbl_q       <= q_lbl_d;
      q_root_q      <= q_root_d;
`ifdef FCC_UF_PATH_COMPRESS_EN
      start_q       <= start_d;
      hop_q         <= hop_d;
      ret_q         <= ret_d;
`endif
    end
  end

  assign uf_if.merge_ready = merge_ready_w;
  assign uf_if.q_ready     = q_ready_w;
  assign uf_if.q_out_valid = q_out_valid_q;
  assign uf_if.q_root      = q_root_q;
  assign init_done         = init_done_q;
  assign lbl_overflow      = ovf_q;
endmodule
